// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: holds a taken branch until its delay slot is in the pipe,
// then presents the target to fetch with a valid/ready handshake. Exceptions preempt branches.
module branch_redirect_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             ds_fetched,
  input  logic             if_inst_valid,
  input  logic             exc_valid,
  input  logic [PC_W-1:0]  exc_pc,
  input  logic             redir_ready,
  output logic             redir_valid,
  output logic [PC_W-1:0]  redir_pc,
  output logic             flush_fetch,
  output logic             busy,
  output logic [CNT_W-1:0] redir_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_DS = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            fire;

  assign redir_valid = (state == S_ISSUE);
  assign fire        = redir_valid & redir_ready;
  assign flush_fetch = fire;
  assign busy        = (state != S_IDLE);

  // Exceptions override everything, including a handshake completing this cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = redir_pc;
    if (exc_valid) begin
      state_nxt = S_ISSUE;
      pc_nxt    = exc_pc;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_valid && br_taken) begin
            pc_nxt    = br_target;
            state_nxt = ds_fetched ? S_ISSUE : S_WAIT_DS;
          end
        end
        S_WAIT_DS: begin
          if (if_inst_valid) state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          if (redir_ready) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      redir_pc    <= RESET_PC;
      redir_count <= '0;
    end else begin
      state    <= state_nxt;
      redir_pc <= pc_nxt;
      if (fire) redir_count <= redir_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboarded bench for branch_redirect_ctrl: directed scenarios followed by random traffic,
// compared cycle by cycle against a pending-redirect reference model.
module tb_branch_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_valid, br_taken, ds_fetched, if_inst_valid, exc_valid, redir_ready;
  logic [31:0] br_target, exc_pc;
  logic        redir_valid, flush_fetch, busy;
  logic [31:0] redir_pc;
  logic [3:0]  redir_count;

  branch_redirect_ctrl #(.PC_W(32), .RESET_PC(RST_PC), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .ds_fetched(ds_fetched), .if_inst_valid(if_inst_valid),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .redir_ready(redir_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .flush_fetch(flush_fetch),
    .busy(busy), .redir_count(redir_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        flush;
    logic        busy;
    logic [3:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: a redirect is "pending" from acceptance until it is handed to fetch;
  // while it still lacks its delay slot it is not yet offered.
  logic        m_pend, m_need_ds;
  logic [31:0] m_pc;
  logic [3:0]  m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_need_ds = 1'b0; m_pc = RST_PC; m_cnt = 4'd0;
  endtask

  // Called at posedge+1: drive one cycle of inputs, predict outputs, advance model, wait edge.
  task automatic drive(input logic bv, input logic bt, input logic [31:0] tgt, input logic dsf,
                       input logic ifv, input logic ev, input logic [31:0] epc, input logic rdy);
    exp_t e;
    logic offer, handed;
    br_valid = bv; br_taken = bt; br_target = tgt; ds_fetched = dsf;
    if_inst_valid = ifv; exc_valid = ev; exc_pc = epc; redir_ready = rdy;
    offer   = resetn && m_pend && !m_need_ds;
    handed  = offer && rdy;
    e.vld   = offer;
    e.pc    = m_pc;
    e.flush = handed;
    e.busy  = m_pend;
    e.cnt   = m_cnt;
    e.cyc   = cyc;
    exp_q.push_back(e);
    if (!resetn) model_reset();
    else begin
      if (handed) m_cnt = m_cnt + 4'd1;
      if (ev) begin
        m_pend = 1'b1; m_need_ds = 1'b0; m_pc = epc;
      end else if (handed) begin
        m_pend = 1'b0;
      end else if (!m_pend) begin
        if (bv && bt) begin m_pend = 1'b1; m_need_ds = !dsf; m_pc = tgt; end
      end else if (m_need_ds && ifv) begin
        m_need_ds = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  task automatic branch(input logic [31:0] tgt, input logic dsf);
    drive(1'b1, 1'b1, tgt, dsf, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("redir_valid", {31'd0, redir_valid}, {31'd0, e.vld}, e.cyc);
      chk("redir_pc", redir_pc, e.pc, e.cyc);
      chk("flush_fetch", {31'd0, flush_fetch}, {31'd0, e.flush}, e.cyc);
      chk("busy", {31'd0, busy}, {31'd0, e.busy}, e.cyc);
      chk("redir_count", {28'd0, redir_count}, {28'd0, e.cnt}, e.cyc);
    end
  end

  initial begin
    resetn = 1'b0;
    br_valid = 0; br_taken = 0; br_target = 0; ds_fetched = 0;
    if_inst_valid = 0; exc_valid = 0; exc_pc = 0; redir_ready = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_valid", {31'd0, redir_valid}, 32'd0, cyc);
    chk("reset_pc", redir_pc, RST_PC, cyc);
    chk("reset_busy", {31'd0, busy}, 32'd0, cyc);
    chk("reset_count", {28'd0, redir_count}, 32'd0, cyc);
    resetn = 1'b1;

    // Taken branch, delay slot already present, fetch ready immediately
    branch(32'h8000_0100, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Delay slot missing for 3 cycles, then fetch stalls the redirect 5 cycles
    branch(32'h8000_0300, 1'b0);
    repeat (3) idle(1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Exception while waiting for the delay slot replaces the branch
    branch(32'h8000_0200, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(1'b0);

    // Not-taken branch, then a second branch offered while busy
    drive(1'b1, 1'b0, 32'h8000_0400, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    branch(32'h8000_0500, 1'b0);
    drive(1'b1, 1'b1, 32'h8000_0600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h8000_0700, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h8000_0800, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b0);

    // Exception and branch together, then exception coinciding with a fire
    drive(1'b1, 1'b1, 32'h8000_0900, 1'b1, 1'b0, 1'b1, 32'hBFC0_0200, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0180, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Enough fires to wrap the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      branch(32'h8000_1000 + 32'(i * 4), 1'b1);
      idle(1'b1);
    end
    idle(1'b0);

    // Asynchronous reset in the middle of an ISSUE stall
    branch(32'h8000_2000, 1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("async_valid", {31'd0, redir_valid}, 32'd0, cyc);
    chk("async_flush", {31'd0, flush_fetch}, 32'd0, cyc);
    chk("async_pc", redir_pc, RST_PC, cyc);
    chk("async_count", {28'd0, redir_count}, 32'd0, cyc);
    model_reset();
    @(posedge clk); #1;
    idle(1'b1);
    resetn = 1'b1;
    idle(1'b0);

    // Random traffic, including branches offered while busy and stray exceptions
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 1) == 1);
    end
    idle(1'b0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
